// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and helpers for the FIFO read-side stream stage.
package fifo_rd_stream_pkg;

    localparam int unsigned BUF_DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF     = 16;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    typedef logic [$clog2(BUF_DEPTH_DEF):0] occ_def_t;

endpackage

// File: rtl/stream_prefetch_buf.sv
// Circular prefetch buffer: write strobe, read-advance strobe and occupancy count.
module stream_prefetch_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = BUF_DEPTH_DEF,
    localparam int unsigned PW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_adv,
    output logic [WIDTH-1:0] rd_data,
    output logic [PW:0]      occupancy
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      occ_q;

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_adv) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({wr_en, rd_adv})
                2'b10:   occ_q <= occ_q + (PW+1)'(1);
                2'b01:   occ_q <= occ_q - (PW+1)'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign rd_data   = mem[rd_ptr_q];
    assign occupancy = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side stage: credit-based popping, latency absorption, valid/ready output.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    localparam int unsigned OW       = ptr_w(BUF_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] word_cnt,
    output logic [OW-1:0]    occupancy
);

    localparam logic [OW:0] DepthL = (OW+1)'(BUF_DEPTH);

    logic             inflight_q;
    logic             fire;
    logic [OW:0]      credit;
    logic [CNT_W-1:0] word_cnt_q;

    // Credit counts buffered plus in-flight words so the buffer can never overflow;
    // only registered state feeds it, keeping out_ready off the pop path.
    assign credit     = {1'b0, occupancy} + {{OW{1'b0}}, inflight_q};
    assign fifo_rd_en = !rst && !flush && !fifo_empty && (credit < DepthL);
    assign out_valid  = (occupancy != '0);
    assign fire       = out_valid && out_ready;

    // fifo_rd_en is low during flush, so this also cancels the in-flight pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_q <= '0;
        end else if (fire) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
        end
    end

    assign word_cnt = word_cnt_q;

    stream_prefetch_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_en     (inflight_q),
        .wr_data   (fifo_rd_data),
        .rd_adv    (fire),
        .rd_data   (out_data),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        out_ready;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_en, fifo_rd_en_s;
    logic        out_valid, out_valid_s;
    logic [7:0]  out_data, out_data_s;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt_s;
    logic [2:0]  occupancy, occupancy_s;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_mem [64];
    int         fifo_head = 0;
    int         fifo_tail = 0;
    int         pop_cnt   = 0;
    int         pop_base;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .WIDTH     (8),
        .BUF_DEPTH (4),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .word_cnt     (word_cnt),
        .occupancy    (occupancy)
    );

    // Narrow-counter twin sharing the same stimulus, for the wrap check.
    fifo_rd_stream #(
        .WIDTH     (8),
        .BUF_DEPTH (4),
        .CNT_W     (4)
    ) dut_s (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en_s),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .out_valid    (out_valid_s),
        .out_ready    (out_ready),
        .out_data     (out_data_s),
        .word_cnt     (word_cnt_s),
        .occupancy    (occupancy_s)
    );

    assign fifo_empty = (fifo_head == fifo_tail);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fifo_mem[fifo_head[5:0]];
            fifo_head    <= fifo_head + 1;
            pop_cnt      <= pop_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        fifo_mem[fifo_tail[5:0]] = v;
        fifo_tail++;
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) begin
            if (out_valid && out_ready) begin
                chk(tag, {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
            tick();
        end
        chk({tag, "_done"}, exp_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;

        // Idle after reset with an empty FIFO.
        for (int i = 0; i < 10; i++) begin
            chk("idle_rd_en", fifo_rd_en, 0);
            chk("idle_valid", out_valid, 0);
            chk("idle_cnt", word_cnt, 0);
            chk("idle_occ", occupancy, 0);
            tick();
        end

        // Streaming at full rate.
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        out_ready = 1'b1;
        #1;
        for (int c = 0; c <= 10; c++) begin
            chk("stream_rd_en", fifo_rd_en, (c <= 7) ? 1 : 0);
            chk("stream_valid", out_valid, (c >= 2 && c <= 9) ? 1 : 0);
            if (c >= 2 && c <= 9) chk("stream_data", out_data, 8'h11 + c - 2);
            tick();
        end
        chk("stream_cnt", word_cnt, 8);
        chk("stream_cnt_s", word_cnt_s, 8);

        // Back-pressure: buffer fills, pops stop, head word holds.
        out_ready = 1'b0;
        pop_base  = pop_cnt;
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        #1;
        for (int c = 0; c <= 7; c++) begin
            chk("stall_rd_en", fifo_rd_en, (c <= 3) ? 1 : 0);
            if (c >= 2) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, 8'h11);
            end
            if (c >= 5) begin
                chk("stall_occ", occupancy, 4);
                chk("stall_occ_s", occupancy_s, 4);
                chk("stall_valid_s", out_valid_s, 1);
                chk("stall_data_s", out_data_s, 8'h11);
                chk("stall_rd_en_s", fifo_rd_en_s, 0);
            end
            tick();
        end
        chk("stall_pops", pop_cnt - pop_base, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h11 + 8'(i));
        drain("stall_drain", 24);
        chk("drain_cnt", word_cnt, 16);
        chk("drain_cnt_s", word_cnt_s, 0);

        // Flush with two buffered words and one in flight; a fire in the flush cycle counts.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
        #1;
        repeat (3) tick();
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("flush_occ_before", occupancy, 2);
        chk("flush_data", out_data, 8'hA0);
        chk("flush_rd_en", fifo_rd_en, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_occ_after", occupancy, 0);
        chk("flush_valid_after", out_valid, 0);
        chk("flush_cnt", word_cnt, 17);
        chk("wrap_cnt_s", word_cnt_s, 1);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'hA4);
        exp_q.push_back(8'hA5);
        drain("flush_drain", 16);
        chk("flush_drain_cnt", word_cnt, 20);
        chk("flush_drain_cnt_s", word_cnt_s, 4);

        // Asynchronous reset with three buffered words and a pop in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
        #1;
        repeat (4) tick();
        chk("rst_occ_before", occupancy, 3);
        chk("rst_valid_before", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_cnt", word_cnt, 0);
        chk("rst_cnt_s", word_cnt_s, 0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 4; i < 8; i++) exp_q.push_back(8'hB0 + 8'(i));
        drain("rst_drain", 16);
        chk("rst_drain_cnt", word_cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
